// File: rtl/dev_bus_arbiter_if.sv
// dev_bus_arbiter_if -- one master's port onto the shared peripheral bus.
//   req/we/addr/wd : request from the master (addr is a word address [31:2])
//   ack/rd/err     : one-cycle completion pulse, read data and fault flag
// modport master : the requesting side (CPU mem stage, DMA/debug, testbench)
// modport slave  : the arbiter side
interface dev_bus_arbiter_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wd;
  logic        ack;
  logic [31:0] rd;
  logic        err;

  modport master (output req, we, addr, wd, input  ack, rd, err);
  modport slave  (input  req, we, addr, wd, output ack, rd, err);
endinterface

// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter -- shared peripheral bus between two masters and two timers.
//   Arbitrates m0 (CPU) / m1 (DMA/debug), decodes the word address to DEV0 or
//   DEV1, runs a single-outstanding IDLE -> ACCESS -> RESP access and returns
//   ack/rd/err to the winner. Also registers the HWInt[15:10] vector.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   m0, m1            : master ports (dev_bus_arbiter_if.slave)
//   dev_addr, dev_wd  : shared word offset / write data, driven only in ACCESS
//   dev0_we, dev1_we  : one-cycle write strobes
//   dev0_rd, dev1_rd  : combinational device read data
//   dev0_irq, dev1_irq, ext_irq : interrupt sources
//   hwint             : registered {ext_irq, dev1_irq, dev0_irq}
// Build option: ARB_RR_EN selects round-robin arbitration on contention;
//   without it master 0 always wins contention.
module dev_bus_arbiter #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7f10,
  parameter int          DEV_WORDS = 3,
  parameter int          RO_WORD   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  dev_bus_arbiter_if.slave        m0,
  dev_bus_arbiter_if.slave        m1,
  output logic [1:0]              dev_addr,
  output logic [31:0]             dev_wd,
  output logic                    dev0_we,
  output logic                    dev1_we,
  input  logic [31:0]             dev0_rd,
  input  logic [31:0]             dev1_rd,
  input  logic                    dev0_irq,
  input  logic                    dev1_irq,
  input  logic [3:0]              ext_irq,
  output logic [5:0]              hwint
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [29:0] B0 = DEV0_BASE[31:2];
  localparam logic [29:0] B1 = DEV1_BASE[31:2];

  typedef struct packed {
    logic        id;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wd;
  } req_t;

  logic [1:0]  state;
  logic        last_grant;
  req_t        q;
  logic [31:0] rd_q;
  logic        err_q;

  logic [1:0]  req;
  logic        gnt_nxt;
  assign req = {m1.req, m0.req};

  // ---- arbitration ----
`ifdef ARB_RR_EN
  always_comb begin
    if (req == 2'b11) gnt_nxt = ~last_grant;
    else              gnt_nxt = req[1] & ~req[0];
  end
`else
  // Master 0 wins whenever it requests; last_grant is kept for compatibility.
  always_comb gnt_nxt = ~req[0];
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // ---- decode of the latched address ----
  // Unsigned subtract: addresses below a base wrap to huge offsets, so one
  // compare covers both range ends.
  logic [29:0] off0, off1;
  logic        hit0, hit1, err_w;
  logic [1:0]  off;
  always_comb begin
    off0  = q.addr - B0;
    off1  = q.addr - B1;
    hit0  = off0 < 30'(DEV_WORDS);
    hit1  = off1 < 30'(DEV_WORDS);
    off   = hit1 ? off1[1:0] : off0[1:0];
    err_w = !(hit0 || hit1) || (q.we && off == 2'(RO_WORD));
  end

  // ---- state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      q          <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      hwint      <= '0;
    end else begin
      hwint <= {ext_irq, dev1_irq, dev0_irq};
      case (state)
        S_IDLE: if (|req) begin
          q.id       <= gnt_nxt;
          q.we       <= gnt_nxt ? m1.we   : m0.we;
          q.addr     <= gnt_nxt ? m1.addr : m0.addr;
          q.wd       <= gnt_nxt ? m1.wd   : m0.wd;
          last_grant <= gnt_nxt;
          state      <= S_ACCESS;
        end
        S_ACCESS: begin
          if (q.we)      rd_q <= '0;
          else if (hit0) rd_q <= dev0_rd;
          else if (hit1) rd_q <= dev1_rd;
          else           rd_q <= '0;
          err_q <= err_w;
          state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- outputs ----
  // Gated by reset so a reset landing in ACCESS/RESP never leaks a strobe or ack.
  logic in_acc, in_resp;
  assign in_acc  = (state == S_ACCESS) && !reset;
  assign in_resp = (state == S_RESP) && !reset;

  assign dev_addr = in_acc ? off  : 2'b0;
  assign dev_wd   = in_acc ? q.wd : 32'b0;
  assign dev0_we  = in_acc && q.we && hit0 && !err_w;
  assign dev1_we  = in_acc && q.we && hit1 && !err_w;

  assign m0.ack = in_resp && !q.id;
  assign m0.rd  = m0.ack ? rd_q : 32'b0;
  assign m0.err = m0.ack && err_q;
  assign m1.ack = in_resp && q.id;
  assign m1.rd  = m1.ack ? rd_q : 32'b0;
  assign m1.err = m1.ack && err_q;
endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb_dev_bus_arbiter -- scoreboard bench for dev_bus_arbiter.
// Expected responses are queued when a request is driven and compared by a
// monitor at each falling edge where an ack appears.
module tb_dev_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  dev_bus_arbiter_if m0_if ();
  dev_bus_arbiter_if m1_if ();

  logic [1:0]  dev_addr;
  logic [31:0] dev_wd;
  logic        dev0_we, dev1_we;
  logic [31:0] dev0_rd, dev1_rd;
  logic        dev0_irq, dev1_irq;
  logic [3:0]  ext_irq;
  logic [5:0]  hwint;

  dev_bus_arbiter dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
    .dev_addr(dev_addr), .dev_wd(dev_wd), .dev0_we(dev0_we), .dev1_we(dev1_we),
    .dev0_rd(dev0_rd), .dev1_rd(dev1_rd), .dev0_irq(dev0_irq), .dev1_irq(dev1_irq),
    .ext_irq(ext_irq), .hwint(hwint)
  );

  typedef struct {
    int          mid;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%h exp=%h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---- response monitor ----
  always @(negedge clk) begin
    if (m0_if.ack || m1_if.ack) begin
      if (sbq.size() == 0) chk("unexp_ack", {30'b0, m1_if.ack, m0_if.ack}, 32'b0);
      else begin
        mon_e = sbq.pop_front();
        chk("ack_both", {31'b0, m0_if.ack & m1_if.ack}, 32'b0);
        chk("ack_id",   {31'b0, m1_if.ack}, mon_e.mid[31:0]);
        chk("ack_rd",   m1_if.ack ? m1_if.rd : m0_if.rd, mon_e.rd);
        chk("ack_err",  {31'b0, m1_if.ack ? m1_if.err : m0_if.err}, {31'b0, mon_e.err});
        chk("ack_cyc",  cyc, mon_e.cyc);
        chk("loser_out", m1_if.ack ? (m0_if.rd | {31'b0, m0_if.err}) :
                                     (m1_if.rd | {31'b0, m1_if.err}), 32'b0);
      end
    end
  end

  task automatic drive(input int mid, input logic r, input logic we,
                       input logic [31:0] baddr, input logic [31:0] wd);
    if (mid == 0) begin
      m0_if.req = r; m0_if.we = we; m0_if.addr = baddr[31:2]; m0_if.wd = wd;
    end else begin
      m1_if.req = r; m1_if.we = we; m1_if.addr = baddr[31:2]; m1_if.wd = wd;
    end
  endtask

  task automatic push(input int mid, input logic [31:0] rd, input logic err, input int at);
    exp_t e;
    e.mid = mid; e.rd = rd; e.err = err; e.cyc = at;
    sbq.push_back(e);
  endtask

  // Called #1 after a rising edge while the DUT is in IDLE; returns the same way.
  task automatic do_acc(input int mid, input logic we, input logic [31:0] baddr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic [1:0] exp_we,
                        input logic [1:0] exp_da);
    push(mid, exp_rd, exp_err, cyc + 2);
    drive(mid, 1'b1, we, baddr, wd);
    @(posedge clk); #1;
    drive(mid, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("dev_we", {30'b0, dev1_we, dev0_we}, {30'b0, exp_we});
    if (exp_we != 2'b00) begin
      chk("dev_addr", {30'b0, dev_addr}, {30'b0, exp_da});
      chk("dev_wd", dev_wd, wd);
    end
    for (int i = 0; i < 4 && sbq.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sbq.size() != 0) begin
      chk("ack_timeout", sbq.size(), 32'b0);
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout obs=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  int base;
  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    dev0_rd = 32'hD0D0_0001; dev1_rd = 32'h0000_CAFE;
    dev0_irq = 1'b0; dev1_irq = 1'b0; ext_irq = 4'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   {30'b0, m1_if.ack, m0_if.ack}, 32'b0);
    chk("rst_rd",    m0_if.rd | m1_if.rd, 32'b0);
    chk("rst_we",    {30'b0, dev1_we, dev0_we}, 32'b0);
    chk("rst_daddr", {30'b0, dev_addr}, 32'b0);
    chk("rst_dwd",   dev_wd, 32'b0);
    chk("rst_hwint", {26'b0, hwint}, 32'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single accesses: mid, we, byte addr, wd, exp rd, exp err, exp strobes, exp offset
    do_acc(0, 1, 32'h7f04, 32'h0000_1234, 32'h0,         0, 2'b01, 2'd1);
    do_acc(1, 0, 32'h7f18, 32'h0,         32'h0000_CAFE, 0, 2'b00, 2'd0);
    do_acc(0, 1, 32'h7f08, 32'h0000_0BAD, 32'h0,         1, 2'b00, 2'd0);
    do_acc(0, 0, 32'h3000, 32'h0,         32'h0,         1, 2'b00, 2'd0);
    do_acc(1, 1, 32'h7f14, 32'h0000_55AA, 32'h0,         0, 2'b10, 2'd1);
    do_acc(0, 0, 32'h7f0c, 32'h0,         32'h0,         1, 2'b00, 2'd0);
    do_acc(1, 0, 32'h7f10, 32'h0,         32'h0000_CAFE, 0, 2'b00, 2'd0);
    do_acc(0, 0, 32'h7efc, 32'h0,         32'h0,         1, 2'b00, 2'd0);
    do_acc(1, 0, 32'h7f00, 32'h0,         32'hD0D0_0001, 0, 2'b00, 2'd0);
    do_acc(0, 1, 32'h7f10, 32'h0000_0077, 32'h0,         0, 2'b10, 2'd0);

    // reset in ACCESS of a write: no strobe, no ack, normal service afterwards
    drive(0, 1'b1, 1'b1, 32'h7f00, 32'h0000_DEAD);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we",  {30'b0, dev1_we, dev0_we}, 32'b0);
    chk("rst_mid_ack", {30'b0, m1_if.ack, m0_if.ack}, 32'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_noack", {30'b0, m1_if.ack, m0_if.ack}, 32'b0);
    end
    @(posedge clk); #1;
    do_acc(0, 1, 32'h7f00, 32'h0000_BEEF, 32'h0, 0, 2'b01, 2'd0);

    // contention after reset: both held for three access slots
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h7f00, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h7f14, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    base = cyc;
`ifdef ARB_RR_EN
    push(0, 32'hD0D0_0001, 0, base + 2);
    push(1, 32'h0000_CAFE, 0, base + 5);
    push(0, 32'hD0D0_0001, 0, base + 8);
`else
    push(0, 32'hD0D0_0001, 0, base + 2);
    push(0, 32'hD0D0_0001, 0, base + 5);
    push(0, 32'hD0D0_0001, 0, base + 8);
`endif
    repeat (8) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("cont_drained", sbq.size(), 32'b0);
    sbq.delete();
    @(posedge clk); #1;

    // interrupt vector
    dev1_irq = 1'b1; ext_irq = 4'b1000;
    @(negedge clk);
    chk("hwint_lat", {26'b0, hwint}, 32'b0);
    @(posedge clk); #1;
    chk("hwint_val", {26'b0, hwint}, 32'b0010_0010);
    dev0_irq = 1'b1; ext_irq = 4'b0001;
    @(posedge clk); #1;
    chk("hwint_val2", {26'b0, hwint}, 32'b0000_0111);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("hwint_rst", {26'b0, hwint}, 32'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
Shared peripheral-bus controller between two masters and the two timer devices. Master 0 is the CPU memory stage; master 1 is a DMA/debug port.
- Arbitrates requests and decodes addresses to DEV0 (timer at 0x7f00) or DEV1 (timer at 0x7f10).
- Sequences a single-outstanding, 3-state access and returns data, ack and error to the winning master.
- Registers device interrupt lines into the HWInt[15:10] vector consumed by CP0.

Parameters:
DEV0_BASE, 32'h0000_7f00, byte base address of device 0
DEV1_BASE, 32'h0000_7f10, byte base address of device 1
DEV_WORDS, 3, number of 32-bit registers per device (word offsets 0..DEV_WORDS-1)
RO_WORD, 2, word offset of the read-only Count register in each device

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  master 0 request (level)
m0_we  in  1  master 0 write enable
m0_addr  in  30  master 0 word address [31:2]
m0_wd  in  32  master 0 write data
m0_ack  out  1  master 0 one-cycle completion pulse
m0_rd  out  32  master 0 read data, valid with m0_ack
m0_err  out  1  master 0 access fault, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wd, m1_ack, m1_rd, m1_err  same as m0_*, for master 1
dev_addr  out  2  word offset to devices (shared)
dev_wd  out  32  write data to devices (shared)
dev0_we  out  1  device 0 write strobe
dev1_we  out  1  device 1 write strobe
dev0_rd  in  32  device 0 combinational read data
dev1_rd  in  32  device 1 combinational read data
dev0_irq  in  1  device 0 interrupt
dev1_irq  in  1  device 1 interrupt
ext_irq  in  4  external interrupt sources
hwint  out  6  registered interrupt vector, maps to HWInt[15:10]

Behaviour:
- Reset: state IDLE, all outputs 0, last_grant = 1 (master 0 wins the first contention).
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE, which waits.
- IDLE:
  - If any req is high, choose a winner.
  - Latch master id, we, addr and wd; update last_grant; go to ACCESS.
  - Requests are sampled only in IDLE; req seen in other states is ignored.
- Decode of latched addr:
  - hit0 = addr in [DEV0_BASE>>2, (DEV0_BASE>>2)+DEV_WORDS-1]; hit1 is the same for DEV1_BASE.
  - dev_addr = addr - base (2 bits).
  - err = (no hit) OR (we AND offset == RO_WORD).
- ACCESS:
  - dev_addr and dev_wd are driven from the latches.
  - devN_we = 1 for this single cycle only if we AND hitN AND !err.
  - Read data is captured at the end of the cycle: dev0_rd if hit0, dev1_rd if hit1, else 0. Writes capture 0.
- RESP:
  - Winner's ack = 1 with rd and err for one cycle; the other master's outputs stay 0.
  - Next state is IDLE.
- Latency: req sampled in IDLE at cycle t -> ack at cycle t+2. Throughput is one access per 3 cycles.
- Master rule: req must be low in the cycle after ack. A req still high in IDLE is a new request.
- dev_addr, dev_wd and devN_we are 0 outside ACCESS.
- hwint = {ext_irq[3:0], dev1_irq, dev0_irq}, registered with 1-cycle latency; reset value 0.
- Reset asserted mid-transaction: FSM returns to IDLE, the pending access is discarded, no ack and no write strobe occur.
- Simultaneous requests: see Optional Feature. A non-winning request stays pending and is served on the next IDLE.

Optional Feature:
ARB_RR_EN
- Defined: round-robin arbitration. On contention, grant the master != last_grant; a single requester always wins.
- Undefined: fixed priority, master 0 (CPU) always wins contention; last_grant is still maintained but unused.

Test Plan:
- m0 write addr 0x7f04>>2, wd 0x1234 -> dev0_we=1 for one cycle at t+1 with dev_addr=1, dev_wd=0x1234; m0_ack=1, m0_err=0 at t+2.
- m1 read 0x7f18>>2 with dev1_rd=0xCAFE -> m1_ack at t+2 with m1_rd=0xCAFE, m1_err=0; dev1_we stays 0.
- m0 write to 0x7f08 (Count) -> no dev0_we, m0_err=1; m0 read of 0x3000 -> m0_err=1, m0_rd=0.
- Both reqs held high after reset:
  - With ARB_RR_EN, grants alternate m0, m1, m0 (acks at cycles 2, 5, 8).
  - Without it, m0 is served on each IDLE while held.
- Reset asserted in ACCESS of a write -> no dev0_we, no ack; state IDLE next cycle; following request served normally.
- dev1_irq=1, ext_irq=4'b1000 -> hwint=6'b100010 one cycle later; reset clears hwint to 0.
